relay_arbiter: RTL
==================

# relay_arbiter

Clocked controller that shares one battery between `N_REQ` relays, allowing only one coil to be energized at a time. It sequences each relay through make (contact settle), hold and break (release dead time) phases, and arbitrates between requesters in round-robin order. It sits between requesting logic and the relay bank. `coil[i]` drives the switch input of relay `i`. `grant[i]` tells requester `i` that relay `i`'s output contacts are settled and usable.

## Interface
- `N_REQ`, 4: number of requesters/relays (2..16).
- `SETTLE_CYCLES`, 3: cycles the coil is held before grant asserts (≥1).
- `RELEASE_CYCLES`, 2: dead cycles after a coil drops before arbitration resumes (≥1).

- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `req` input N_REQ: request lines; level-sensitive, held high for as long as the relay is needed.
- `coil` output N_REQ: relay coil drive; one-hot or zero.
- `grant` output N_REQ: contacts settled; one-hot or zero; `grant[i]` implies `coil[i]`.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- Reset values:
  - `coil=0`, `grant=0`, `busy=0`.
  - State IDLE, round-robin pointer `ptr=0`, timer 0.
- States are IDLE, MAKE, HOLD and BREAK. The owner index `own` is registered.
- IDLE:
  - If any `req` bit is high, select the first set bit searching `ptr`, `ptr+1`, … modulo `N_REQ`.
  - Load `own` with that index, set `coil[own]`, load the timer with `SETTLE_CYCLES`, and go to MAKE.
  - Otherwise stay in IDLE.
- MAKE:
  - Decrement the timer each cycle.
  - If `req[own]` drops, clear the coil, load the timer with `RELEASE_CYCLES`, go to BREAK, and never assert grant.
  - If the timer reaches 0 (after `SETTLE_CYCLES` cycles in MAKE), set `grant[own]` and go to HOLD.
- HOLD:
  - Hold `coil` and `grant` while `req[own]` is high.
  - When `req[own]` is low, clear `coil` and `grant`, load the timer with `RELEASE_CYCLES`, and go to BREAK.
- BREAK:
  - Keep all coils off and decrement the timer.
  - At 0, set `ptr = (own+1) mod N_REQ` and go to IDLE.
- The pointer updates only on leaving BREAK, including for aborted MAKE phases. This guarantees fairness: a continuously requesting input waits at most `N_REQ-1` other services.
- Requests from non-owners are ignored outside IDLE and need not be latched. A requester must keep `req` high to be served.
- Timer width: `$clog2(max(SETTLE_CYCLES,RELEASE_CYCLES)+1)`. It never wraps; it saturates at 0.
- Invariants that must hold every cycle:
  - `coil` and `grant` are each at most one-hot.
  - `grant & ~coil == 0`.
  - No two coils are ever high in the same cycle, or in adjacent cycles without the BREAK gap.

## Timing
- All outputs are registered; there is no combinational path from `req` to any output.
- `req[i]` sampled high in IDLE at edge k:
  - `coil[i]` and `busy` rise after edge k.
  - `grant[i]` rises after edge k+SETTLE_CYCLES.
- `req[own]` sampled low in HOLD at edge m:
  - `coil` and `grant` fall after edge m.
  - State returns to IDLE after edge m+RELEASE_CYCLES, and `busy` falls then if no request is pending.
  - The earliest next coil rises after edge m+RELEASE_CYCLES+1.
- Minimum coil-off gap between two owners is RELEASE_CYCLES+1 cycles.
- `req` dropping in the same cycle the MAKE timer expires:
  - The abort wins; the bench must see the transition to BREAK and no grant pulse.
- Simultaneous requests in IDLE are resolved purely by `ptr`; the bit order is rotated, not fixed.
- Reset asserted mid-operation (any state):
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - State returns to IDLE with `ptr=0`.
  - No BREAK dead time is enforced after reset deasserts.

## Test plan
- **Reset:** assert `reset` with `req=4'b1111` → `coil`, `grant` and `busy` are 0 during reset. After release, `coil=0001` rises on the first edge and `grant=0001` three edges later.
- **Single request:** `req=0010` at edge 10, dropped at edge 20 → `coil[1]` is high after edges 10–20, `grant[1]` after edges 13–20, `busy` falls after edge 22.
- **Round-robin:** hold `req=1111`, with each owner dropping its request 2 cycles after grant and re-raising it → owners serve in order 0, 1, 2, 3, 0. The gap between coil-off and the next coil-on is 3 cycles every time.
- **Abort in MAKE:** `req=0100` high at edge 5, low at edge 6 → `coil[2]` is high for 1 cycle, `grant` stays 0, BREAK lasts 2 cycles, then `ptr=3`.
- **Simultaneous drop/expire:** `req[0]` falls on the same edge that the MAKE timer hits 0 → no grant pulse, and the state goes to BREAK.
- **Async reset mid-HOLD:** pulse `reset` between clock edges while `grant=1000` → outputs clear before the next edge. Afterwards `req=1000` is re-served starting from `ptr=0`, with `coil[3]` after 1 edge.

Source files
------------

// File: rtl/relay_arbiter.sv
// relay_arbiter: round-robin arbiter sharing one battery between N_REQ relays.
// Only one coil is energized at a time; each owner goes through MAKE (contact
// settle), HOLD (grant asserted) and BREAK (release dead time) before the next.
// Ports:
//   clk   - single clock, all state on the rising edge
//   reset - asynchronous active-high reset, clears all state immediately
//   req   - level-sensitive request lines, held high while the relay is needed
//   coil  - relay coil drive, one-hot or zero (registered)
//   grant - contacts settled, one-hot or zero, implies coil (registered)
//   busy  - high whenever the controller is not IDLE
module relay_arbiter #(
  parameter int N_REQ          = 4,
  parameter int SETTLE_CYCLES  = 3,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] coil,
  output logic [N_REQ-1:0] grant,
  output logic             busy
);

  localparam int MAX_CYC = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAKE  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_BREAK = 2'd3;

  localparam logic [N_REQ-1:0] ONE    = N_REQ'(1);
  localparam logic [TW-1:0]    T_SET  = TW'(SETTLE_CYCLES);
  localparam logic [TW-1:0]    T_REL  = TW'(RELEASE_CYCLES);
  localparam logic [IW-1:0]    LAST   = IW'(N_REQ - 1);

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] own;
  logic [TW-1:0] timer;
  logic [IW-1:0] pick;

  // First set request bit searching ptr, ptr+1, ... modulo N_REQ. The loop
  // runs from the farthest offset down so the nearest offset wins.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IW-1:0]    p);
    logic [IW-1:0] sel;
    logic [IW-1:0] idx;
    sel = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      idx = IW'((int'(p) + j) % N_REQ);
      if (r[idx]) sel = idx;
    end
    return sel;
  endfunction

  assign pick = rr_pick(req, ptr);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      own   <= '0;
      timer <= '0;
      coil  <= '0;
      grant <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            own   <= pick;
            coil  <= ONE << pick;
            timer <= T_SET;
            state <= S_MAKE;
          end
        end
        S_MAKE: begin
          // A dropped request beats timer expiry: no grant pulse on abort.
          if (!req[own]) begin
            coil  <= '0;
            timer <= T_REL;
            state <= S_BREAK;
          end else if (timer <= TW'(1)) begin
            timer <= '0;
            grant <= ONE << own;
            state <= S_HOLD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_HOLD: begin
          if (!req[own]) begin
            coil  <= '0;
            grant <= '0;
            timer <= T_REL;
            state <= S_BREAK;
          end
        end
        default: begin
          // BREAK: coils stay off; pointer moves past the owner only here so
          // aborted services still rotate priority.
          coil  <= '0;
          grant <= '0;
          if (timer <= TW'(1)) begin
            timer <= '0;
            ptr   <= (own == LAST) ? '0 : own + IW'(1);
            state <= S_IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
      endcase
    end
  end

endmodule
